pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter PAY_W, default 128, width of the opaque payload (instr, ext, rs, rt data).
REQ-002 SHALL have parameter PC_W, default 32, width of the PC field.
REQ-003 SHALL have parameter EXC_W, default 5, width of the exception-code field.
REQ-004 SHALL have parameter HANDLER_PC, default 32'h0000_4180, PC loaded into the bubble on exception request.
REQ-005 SHALL have port: clk  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port: in_valid  in  1  upstream entry valid.
REQ-008 SHALL have port: in_ready  out  1  stage can accept an entry.
REQ-009 SHALL have port: in_pc  in  PC_W  entry PC; also the bubble PC source.
REQ-010 SHALL have port: in_bd  in  1  branch-delay flag; also the bubble BD source.
REQ-011 SHALL have port: in_exc  in  EXC_W  exception code.
REQ-012 SHALL have port: in_pay  in  PAY_W  payload.
REQ-013 SHALL have port: out_valid  out  1  head entry valid.
REQ-014 SHALL have port: out_ready  in  1  downstream accepts the head.
REQ-015 SHALL have ports: out_pc (PC_W), out_bd (1), out_exc (EXC_W), out_pay (PAY_W), all outputs, head entry fields.
REQ-016 SHALL have port: flush  in  1  discard contents, insert a zero bubble.
REQ-017 SHALL have port: req  in  1  exception taken; discard contents, insert a bubble at HANDLER_PC.
REQ-018 SHALL have port: count  out  2  occupancy, 0..2.

Function
REQ-019 SHALL hold a 2-entry in-order buffer (head plus skid); in_ready = (count < 2), derived from registered state only.
REQ-020 SHALL push on a rising edge when in_valid && in_ready, and pop when out_valid && out_ready; out_valid = (count != 0).
REQ-021 SHALL have latency 1: an entry pushed at edge N is presented at the outputs after edge N, with no same-cycle combinational bypass.
REQ-022 SHALL, on simultaneous push and pop at count 1, keep count 1 with the pushed entry as the new head.
REQ-023 SHALL not push at count 2; a pop at count 2 promotes the skid entry to head, and in_ready rises the following cycle.
REQ-024 SHALL preserve FIFO order; payload, pc, bd and exc of an entry stay bit-exact.
REQ-025 SHALL, when count 0, drive out_pay = 0 and out_exc = 0, with out_pc/out_bd taken from the bubble registers.
REQ-026 SHALL, on every edge ending with count 0 and neither req nor flush, load in_pc and in_bd into the bubble registers, so a bubble carries the stalled upstream PC/BD.
REQ-027 SHALL, on req, clear both entries (count 0) and set bubble_pc = HANDLER_PC and bubble_bd = 0, ignoring same-cycle push and pop.
REQ-028 SHALL, on flush without req, clear both entries and set bubble_pc = 0 and bubble_bd = 0, ignoring same-cycle push and pop.
REQ-029 SHALL apply priority reset > req > flush > push/pop.
REQ-030 SHALL leave in_ready = 1 in the cycle after req or flush.

Reset
REQ-031 SHALL, while reset = 0, asynchronously force count = 0 and both entries empty, giving out_valid = 0, out_pc = 0, out_bd = 0, out_exc = 0, out_pay = 0 and in_ready = 1.
REQ-032 SHALL, on reset asserted mid-transfer, drop buffered entries with no partial output; operation resumes on the first edge after reset returns to 1.

Verification
REQ-033 SHALL cover: reset low, then high; push pc=0x3000, pay=0xA5 with out_ready=1 -> next cycle out_valid=1, out_pc=0x3000, out_pay=0xA5, count=1.
REQ-034 SHALL cover: out_ready=0; push pc=0x3000 then 0x3004 -> count=2, in_ready=0, third push ignored; out_ready=1 -> pops 0x3000 then 0x3004 in order.
REQ-035 SHALL cover: empty stage, in_valid=0, in_pc=0x3008, in_bd=1 for one edge -> out_valid=0, out_pc=0x3008, out_bd=1, out_pay=0.
REQ-036 SHALL cover: count=2 with req=1, flush=1 and in_valid=1 on one edge -> count=0, out_pc=0x4180, out_bd=0, in_ready=1.
REQ-037 SHALL cover: count=1 with flush=1 only -> count=0, out_pc=0, out_exc=0.
REQ-038 SHALL cover: reset pulled low asynchronously between edges at count=2 -> outputs zero immediately, before the next clk edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (head + skid) with ready/valid handshake,
// flush/exception bubble insertion and bubble PC/BD tracking for stalled upstream.
module pipe_stage_reg #(
  parameter int              PAY_W      = 128,
  parameter int              PC_W       = 32,
  parameter int              EXC_W      = 5,
  parameter logic [PC_W-1:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             in_bd,
  input  logic [EXC_W-1:0] in_exc,
  input  logic [PAY_W-1:0] in_pay,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic             out_bd,
  output logic [EXC_W-1:0] out_exc,
  output logic [PAY_W-1:0] out_pay,
  input  logic             flush,
  input  logic             req,
  output logic [1:0]       count
);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic             bd;
    logic [EXC_W-1:0] exc;
    logic [PAY_W-1:0] pay;
  } entry_t;

  entry_t          head_q, head_d, skid_q, skid_d, in_entry;
  logic [1:0]      count_q, count_d;
  logic [PC_W-1:0] bubble_pc_q, bubble_pc_d;
  logic            bubble_bd_q, bubble_bd_d;
  logic            push, pop;

  assign in_entry  = '{pc: in_pc, bd: in_bd, exc: in_exc, pay: in_pay};
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    head_d      = head_q;
    skid_d      = skid_q;
    count_d     = count_q;
    bubble_pc_d = bubble_pc_q;
    bubble_bd_d = bubble_bd_q;
    if (req) begin
      count_d     = 2'd0;
      bubble_pc_d = HANDLER_PC;
      bubble_bd_d = 1'b0;
    end else if (flush) begin
      count_d     = 2'd0;
      bubble_pc_d = '0;
      bubble_bd_d = 1'b0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            head_d  = in_entry;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_d = in_entry;
          end else if (push) begin
            skid_d  = in_entry;
            count_d = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_d  = skid_q;
            count_d = 2'd1;
          end
        end
      endcase
      // An empty stage mirrors the stalled upstream PC/BD so its bubble is attributable.
      if (count_d == 2'd0) begin
        bubble_pc_d = in_pc;
        bubble_bd_d = in_bd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q      <= '0;
      skid_q      <= '0;
      count_q     <= 2'd0;
      bubble_pc_q <= '0;
      bubble_bd_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      skid_q      <= skid_d;
      count_q     <= count_d;
      bubble_pc_q <= bubble_pc_d;
      bubble_bd_q <= bubble_bd_d;
    end
  end

  assign count   = count_q;
  assign out_pc  = out_valid ? head_q.pc  : bubble_pc_q;
  assign out_bd  = out_valid ? head_q.bd  : bubble_bd_q;
  assign out_exc = out_valid ? head_q.exc : '0;
  assign out_pay = out_valid ? head_q.pay : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: handshake, ordering, bubbles, req/flush, async reset.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [31:0]  in_pc;
  logic         in_bd;
  logic [4:0]   in_exc;
  logic [127:0] in_pay;
  logic         out_valid, out_ready;
  logic [31:0]  out_pc;
  logic         out_bd;
  logic [4:0]   out_exc;
  logic [127:0] out_pay;
  logic         flush, req;
  logic [1:0]   count;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc), .in_pay(in_pay),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_bd(out_bd), .out_exc(out_exc), .out_pay(out_pay),
    .flush(flush), .req(req), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic bd,
                       input logic [4:0] exc, input logic [127:0] pay);
    in_valid = v; in_pc = pc; in_bd = bd; in_exc = exc; in_pay = pay;
  endtask

  initial begin
    reset = 1'b0; out_ready = 1'b0; flush = 1'b0; req = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 5'h0, 128'h0);
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", count, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_pay", out_pay, 0);
    @(negedge clk);
    reset = 1'b1;

    // Single push, latency 1.
    out_ready = 1'b1;
    drive(1'b1, 32'h3000, 1'b0, 5'h0, 128'hA5);
    step();
    check("p1_out_valid", out_valid, 1);
    check("p1_out_pc", out_pc, 32'h3000);
    check("p1_out_pay", out_pay, 128'hA5);
    check("p1_count", count, 1);
    in_valid = 1'b0;
    step();
    check("p1_drain_count", count, 0);

    // Fill both entries, third push refused, drain in order.
    out_ready = 1'b0;
    drive(1'b1, 32'h3000, 1'b0, 5'h1, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    step();
    drive(1'b1, 32'h3004, 1'b1, 5'h2, 128'hDEAD_BEEF_0000_0000_FFFF_FFFF_1234_5678);
    step();
    check("fill_count", count, 2);
    check("fill_in_ready", in_ready, 0);
    drive(1'b1, 32'h3008, 1'b0, 5'h3, 128'h99);
    step();
    check("third_count", count, 2);
    check("third_head_pc", out_pc, 32'h3000);
    check("third_head_pay", out_pay, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("pop1_count", count, 1);
    check("pop1_pc", out_pc, 32'h3004);
    check("pop1_bd", out_bd, 1);
    check("pop1_exc", out_exc, 5'h2);
    check("pop1_pay", out_pay, 128'hDEAD_BEEF_0000_0000_FFFF_FFFF_1234_5678);
    check("pop1_in_ready", in_ready, 1);
    step();
    check("pop2_out_valid", out_valid, 0);

    // Empty stage: bubble tracks upstream PC/BD.
    drive(1'b0, 32'h3008, 1'b1, 5'h7, 128'hFF);
    step();
    check("bub_out_valid", out_valid, 0);
    check("bub_out_pc", out_pc, 32'h3008);
    check("bub_out_bd", out_bd, 1);
    check("bub_out_pay", out_pay, 0);
    check("bub_out_exc", out_exc, 0);

    // Simultaneous push and pop at count 1.
    out_ready = 1'b0;
    drive(1'b1, 32'h3100, 1'b0, 5'h4, 128'hAA);
    step();
    out_ready = 1'b1;
    drive(1'b1, 32'h3104, 1'b0, 5'h5, 128'hBB);
    step();
    check("pp_count", count, 1);
    check("pp_head_pc", out_pc, 32'h3104);
    check("pp_head_pay", out_pay, 128'hBB);

    // req beats flush and push at count 2.
    out_ready = 1'b0;
    drive(1'b1, 32'h3200, 1'b0, 5'h6, 128'hCC);
    step();
    check("pre_req_count", count, 2);
    req = 1'b1; flush = 1'b1;
    drive(1'b1, 32'h5000, 1'b1, 5'h1, 128'hEE);
    step();
    check("req_count", count, 0);
    check("req_out_pc", out_pc, 32'h4180);
    check("req_out_bd", out_bd, 0);
    check("req_in_ready", in_ready, 1);
    req = 1'b0; flush = 1'b0;

    // flush alone at count 1.
    drive(1'b1, 32'h3010, 1'b1, 5'h3, 128'h77);
    step();
    check("pre_flush_count", count, 1);
    check("pre_flush_exc", out_exc, 5'h3);
    flush = 1'b1;
    drive(1'b0, 32'h6000, 1'b1, 5'h0, 128'h0);
    step();
    check("flush_count", count, 0);
    check("flush_out_pc", out_pc, 0);
    check("flush_out_exc", out_exc, 0);
    check("flush_in_ready", in_ready, 1);
    flush = 1'b0;

    // Asynchronous reset mid-cycle at count 2.
    drive(1'b1, 32'h3300, 1'b1, 5'h9, 128'h123);
    step();
    drive(1'b1, 32'h3304, 1'b0, 5'hA, 128'h456);
    step();
    check("pre_arst_count", count, 2);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_count", count, 0);
    check("arst_out_pc", out_pc, 0);
    check("arst_out_bd", out_bd, 0);
    check("arst_out_pay", out_pay, 0);
    check("arst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h3400, 1'b0, 5'h0, 128'h5A);
    step();
    check("resume_count", count, 1);
    check("resume_pc", out_pc, 32'h3400);
    check("resume_pay", out_pay, 128'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
